spi_test_pattern_gen: RTL and testbench

Parametrised stimulus source for the SPI link. After reset it issues a slave-reset pulse, then produces a stream of test words (counter, walking-one, LFSR or constant) and hands each one to the SPI master with a one-cycle START strobe and BUSY handshake. Words are paced by a programmable inter-word gap. The block sits between board-level test control and the SPI master during bring-up and soak testing.

---
 rtl/spi_tpg_pkg.sv | 59 +++++
 rtl/spi_tpg_lfsr.sv | 31 +++
 rtl/spi_test_pattern_gen.sv | 191 +++++++++++++++++++
 tb/tb_spi_test_pattern_gen.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_tpg_pkg.sv
// spi_tpg_pkg -- shared types and helpers for the SPI test pattern generator.
//   tpg_state_e : controller states
//   MODE_*      : pattern select encodings
//   lfsr_taps() : Fibonacci LFSR tap mask (bit i set = tap at stage i+1)
//                 for maximal-length sequences, widths 4..32
package spi_tpg_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_GAP   = 3'd2,
        ST_ISSUE = 3'd3,
        ST_XFER  = 3'd4
    } tpg_state_e;

    localparam logic [1:0] MODE_COUNT = 2'd0;
    localparam logic [1:0] MODE_WALK  = 2'd1;
    localparam logic [1:0] MODE_LFSR  = 2'd2;
    localparam logic [1:0] MODE_CONST = 2'd3;

    // Primitive polynomials, e.g. 8 -> x^8+x^6+x^5+x^4+1 -> stages 8,6,5,4.
    function automatic logic [31:0] lfsr_taps(input int width);
        logic [31:0] t;
        case (width)
            4:  t = 32'h0000_000C;
            5:  t = 32'h0000_0014;
            6:  t = 32'h0000_0030;
            7:  t = 32'h0000_0060;
            8:  t = 32'h0000_00B8;
            9:  t = 32'h0000_0110;
            10: t = 32'h0000_0240;
            11: t = 32'h0000_0500;
            12: t = 32'h0000_0829;
            13: t = 32'h0000_100D;
            14: t = 32'h0000_2015;
            15: t = 32'h0000_6000;
            16: t = 32'h0000_D008;
            17: t = 32'h0001_2000;
            18: t = 32'h0002_0400;
            19: t = 32'h0004_0023;
            20: t = 32'h0009_0000;
            21: t = 32'h0014_0000;
            22: t = 32'h0030_0000;
            23: t = 32'h0042_0000;
            24: t = 32'h00E1_0000;
            25: t = 32'h0120_0000;
            26: t = 32'h0200_0023;
            27: t = 32'h0400_0013;
            28: t = 32'h0900_0000;
            29: t = 32'h1400_0000;
            30: t = 32'h2000_0029;
            31: t = 32'h4800_0000;
            32: t = 32'h8020_0003;
            default: t = 32'h0000_0000;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/spi_tpg_lfsr.sv
// spi_tpg_lfsr -- maximal-length Fibonacci LFSR word source.
//   CLK_1KHZ  : clock
//   RESET_N   : async active-low reset, loads the all-ones seed
//   adv       : advance one step (shift left, feedback into bit 0)
//   word      : current LFSR state, never zero
import spi_tpg_pkg::*;

module spi_tpg_lfsr #(
    parameter int DATA_W = 8
) (
    input  logic              CLK_1KHZ,
    input  logic              RESET_N,
    input  logic              adv,
    output logic [DATA_W-1:0] word
);

    localparam logic [31:0]       TAPS_ALL = lfsr_taps(DATA_W);
    localparam logic [DATA_W-1:0] TAPS     = TAPS_ALL[DATA_W-1:0];
    localparam logic [DATA_W-1:0] SEED     = '1;

    logic fb;
    assign fb = ^(word & TAPS);

    always_ff @(posedge CLK_1KHZ or negedge RESET_N) begin
        if (!RESET_N)
            word <= SEED;
        else if (adv)
            word <= {word[DATA_W-2:0], fb};
    end

endmodule

// File: rtl/spi_test_pattern_gen.sv
// spi_test_pattern_gen -- stimulus source for SPI link bring-up / soak.
// Pulses SLAVE_RESET after reset, then hands a stream of test words
// (counter, walking-one, LFSR, constant) to the SPI master using a
// one-cycle START strobe and the master's BUSY handshake, with a
// programmable idle gap between words.
//   CLK_1KHZ, RESET_N : clock, async active-low reset
//   ENABLE            : run request (level)
//   MODE              : pattern select, sampled when leaving IDLE
//   INTERVAL          : idle cycles between words
//   CONST_WORD        : word used in constant mode
//   BUSY              : SPI master busy
//   DATA, START       : word and one-cycle strobe to the master
//   SLAVE_RESET       : active-high reset to the SPI slave
//   WORD_COUNT        : completed transfers (wraps)
//   ERROR             : sticky transfer timeout, only when
//                       SPI_TPG_TIMEOUT_EN is defined
import spi_tpg_pkg::*;

module spi_test_pattern_gen #(
    parameter int DATA_W         = 8,
    parameter int GAP_W          = 16,
    parameter int RST_CYCLES     = 4,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              CLK_1KHZ,
    input  logic              RESET_N,
    input  logic              ENABLE,
    input  logic [1:0]        MODE,
    input  logic [GAP_W-1:0]  INTERVAL,
    input  logic [DATA_W-1:0] CONST_WORD,
    input  logic              BUSY,
    output logic [DATA_W-1:0] DATA,
    output logic              START,
    output logic              SLAVE_RESET,
    output logic [CNT_W-1:0]  WORD_COUNT
`ifdef SPI_TPG_TIMEOUT_EN
    ,
    output logic              ERROR
`endif
);

    if (RST_CYCLES < 1 || TIMEOUT_CYCLES < 1 || DATA_W < 4 || DATA_W > 32) begin : g_bad_param
        $error("spi_test_pattern_gen: parameter out of range");
    end

    localparam logic [GAP_W-1:0] INIT_GAP = GAP_W'(RST_CYCLES - 1);

    tpg_state_e        state, state_d;
    logic [GAP_W-1:0]  gap_cnt;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] cnt_gen, walk_gen, lfsr_word, pat;
    logic              busy_seen;
    logic              issue, done, gap_load, gap_dec, mode_latch;
    logic              halt, timeout_hit;

    spi_tpg_lfsr #(.DATA_W(DATA_W)) u_lfsr (
        .CLK_1KHZ (CLK_1KHZ),
        .RESET_N  (RESET_N),
        .adv      (done && mode_q == MODE_LFSR),
        .word     (lfsr_word)
    );

    // Completion: BUSY has been seen high since START and is now low.
    assign done = (state == ST_XFER) && busy_seen && !BUSY;

`ifdef SPI_TPG_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;
    logic            err_q;

    always_ff @(posedge CLK_1KHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (issue)
                to_cnt <= '0;
            else if (state == ST_XFER)
                to_cnt <= to_cnt + 1'b1;
            // Completion on the same cycle wins over the timeout.
            err_q <= err_q | ((state == ST_XFER) && !done && timeout_hit);
        end
    end

    assign timeout_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign halt        = err_q;
    assign ERROR       = err_q;
`else
    assign timeout_hit = 1'b0;
    assign halt        = 1'b0;
`endif

    always_comb begin
        case (mode_q)
            MODE_COUNT: pat = cnt_gen;
            MODE_WALK:  pat = walk_gen;
            MODE_LFSR:  pat = lfsr_word;
            default:    pat = CONST_WORD;
        endcase
    end

    always_ff @(posedge CLK_1KHZ or negedge RESET_N) begin
        if (!RESET_N)
            state <= ST_INIT;
        else
            state <= state_d;
    end

    always_comb begin
        state_d    = state;
        gap_load   = 1'b0;
        gap_dec    = 1'b0;
        issue      = 1'b0;
        mode_latch = 1'b0;
        case (state)
            ST_INIT: begin
                if (gap_cnt == '0)
                    state_d = ST_IDLE;
                else
                    gap_dec = 1'b1;
            end
            ST_IDLE: begin
                if (ENABLE && !halt) begin
                    mode_latch = 1'b1;
                    gap_load   = 1'b1;
                    state_d    = ST_GAP;
                end
            end
            ST_GAP: begin
                if (!ENABLE)
                    state_d = ST_IDLE;
                else if (gap_cnt == '0 && !BUSY) begin
                    issue   = 1'b1;
                    state_d = ST_ISSUE;
                end else
                    gap_dec = 1'b1;   // saturates at 0 while BUSY holds us
            end
            ST_ISSUE: state_d = ST_XFER;
            ST_XFER: begin
                if (done) begin
                    if (ENABLE) begin
                        gap_load = 1'b1;
                        state_d  = ST_GAP;
                    end else
                        state_d = ST_IDLE;
                end else if (timeout_hit)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge CLK_1KHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            gap_cnt     <= INIT_GAP;
            mode_q      <= MODE_COUNT;
            DATA        <= '0;
            START       <= 1'b0;
            SLAVE_RESET <= 1'b1;
            WORD_COUNT  <= '0;
            busy_seen   <= 1'b0;
            cnt_gen     <= '0;
            walk_gen    <= DATA_W'(1);
        end else begin
            if (gap_load)
                gap_cnt <= INTERVAL;
            else if (gap_dec && gap_cnt != '0)
                gap_cnt <= gap_cnt - 1'b1;
            if (mode_latch)
                mode_q <= MODE;
            START       <= issue;
            SLAVE_RESET <= (state_d == ST_INIT);
            if (issue)
                DATA <= pat;
            // BUSY high in ISSUE counts as the rise as well.
            if (issue)
                busy_seen <= 1'b0;
            else if ((state == ST_ISSUE || state == ST_XFER) && BUSY)
                busy_seen <= 1'b1;
            if (done) begin
                WORD_COUNT <= WORD_COUNT + 1'b1;
                if (mode_q == MODE_COUNT)
                    cnt_gen <= cnt_gen + 1'b1;
                if (mode_q == MODE_WALK)
                    walk_gen <= {walk_gen[DATA_W-2:0], walk_gen[DATA_W-1]};
            end
        end
    end

endmodule

// File: tb/tb_spi_test_pattern_gen.sv
// tb_spi_test_pattern_gen -- randomized scoreboard bench for
// spi_test_pattern_gen. A reference model derives each expected word from
// the pattern rules (k mod 2^W, 1<<(k mod W), LFSR bit-stream recurrence,
// constant); a monitor pops and compares on every START.
module tb_spi_test_pattern_gen;

    localparam int DATA_W = 8;
    localparam int GAP_W  = 16;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              enable = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic [GAP_W-1:0]  interval = '0;
    logic [DATA_W-1:0] const_word = '0;
    logic              busy = 1'b0;
    logic [DATA_W-1:0] data;
    logic              start;
    logic              slave_reset;
    logic [CNT_W-1:0]  word_count;
`ifdef SPI_TPG_TIMEOUT_EN
    logic              error;
`endif

    always #5 clk = ~clk;

    spi_test_pattern_gen #(
        .DATA_W(DATA_W), .GAP_W(GAP_W), .RST_CYCLES(4), .CNT_W(CNT_W), .TIMEOUT_CYCLES(16)
    ) dut (
        .CLK_1KHZ    (clk),
        .RESET_N     (rst_n),
        .ENABLE      (enable),
        .MODE        (mode),
        .INTERVAL    (interval),
        .CONST_WORD  (const_word),
        .BUSY        (busy),
        .DATA        (data),
        .START       (start),
        .SLAVE_RESET (slave_reset),
        .WORD_COUNT  (word_count)
`ifdef SPI_TPG_TIMEOUT_EN
        ,
        .ERROR       (error)
`endif
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // ---------------- SPI master model: BUSY for busy_len cycles ----------
    int busy_len = 3;
    int bcnt = 0;
    bit busy_stuck = 0;
    bit stuck_arm = 0;
    initial forever begin
        @(negedge clk);
        if (start && stuck_arm) busy_stuck = 1;
        if (start) bcnt = busy_len + 1;
        else if (bcnt > 0) bcnt--;
        busy = busy_stuck || (bcnt >= 1 && bcnt <= busy_len);
    end

    // ---------------- reference model ----------------
    bit lbits[1100];
    int adv[4];
    int exp_wc = 0;

    function automatic logic [7:0] model_word(input int m, input int k);
        logic [7:0] w;
        case (m)
            0: w = 8'(k % 256);
            1: w = 8'(1 << (k % 8));
            2: for (int b = 0; b < 8; b++) w[7-b] = lbits[k+b];
            default: w = const_word;
        endcase
        return w;
    endfunction

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];

    task automatic push_words(input int m, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(model_word(m, adv[m]));
            adv[m]++;
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    int start_cnt = 0;
    int last_start_cyc = -1000;
    int phase_start_cyc = 0;
    int phase_interval = 0;
    bit check_timing = 0;
    bit prev_start = 0;
    initial forever begin
        logic [7:0] e;
        @(negedge clk);
        if (start) begin
            start_cnt++;
            obs_q.push_back(data);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_start: START with no word expected, DATA=0x%0h", data);
            end else begin
                e = exp_q.pop_front();
                if (data !== e) begin
                    errors++;
                    $display("FAIL data: got 0x%0h, expected 0x%0h", data, e);
                end
            end
            checks++;
            if (prev_start) begin
                errors++;
                $display("FAIL start_width: START high on 2 consecutive cycles, expected 1");
            end
            if (check_timing) begin
                if (last_start_cyc < phase_start_cyc)
                    chk("start_latency", cyc - phase_start_cyc, phase_interval + 2);
                else
                    chk("start_period", cyc - last_start_cyc, phase_interval + 3 + busy_len);
            end
            last_start_cyc = cyc;
        end
        prev_start = start;
    end

    // ---------------- stimulus ----------------
    task automatic do_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        #1;
        chk("rst SLAVE_RESET", slave_reset, 1);
        chk("rst START", start, 0);
        chk("rst DATA", data, 0);
        chk("rst WORD_COUNT", word_count, 0);
`ifdef SPI_TPG_TIMEOUT_EN
        chk("rst ERROR", error, 0);
`endif
        chk("rst queue empty", exp_q.size(), 0);
        for (int i = 0; i < 4; i++) adv[i] = 0;
        exp_wc = 0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("SLAVE_RESET release", slave_reset, (k < 4) ? 1 : 0);
        end
        chk("post-rst DATA", data, 0);
        chk("post-rst START", start, 0);
    endtask

    // Sends n words, dropping ENABLE on the n-th START (ISSUE/XFER abort
    // path), so exactly n transfers complete.
    task automatic run_phase(input int m, input int ivl, input int blen, input int n, input bit timing);
        int base = start_cnt;
        int budget;
        push_words(m, n);
        mode            = 2'(m);
        interval        = GAP_W'(ivl);
        busy_len        = blen;
        phase_interval  = ivl;
        check_timing    = timing;
        phase_start_cyc = cyc;
        enable          = 1'b1;
        tick();
        mode = 2'($urandom);   // MODE is only sampled in IDLE
        budget = n * (ivl + blen + 8) + 40;
        while (start_cnt < base + n && budget > 0) begin
            tick();
            budget--;
        end
        enable = 1'b0;
        chk("phase start count", start_cnt, base + n);
        exp_wc += n;
        budget = 40;
        while (word_count !== 16'(exp_wc) && budget > 0) begin
            tick();
            budget--;
        end
        repeat (ivl + 6) tick();
        chk("word_count", word_count, 16'(exp_wc));
        chk("queue drained", exp_q.size(), 0);
        chk("no START after disable", start_cnt, base + n);
        check_timing = 0;
    endtask

    initial begin
        int base;
        int distinct;
        bit seenw[256];

        for (int i = 0; i < 8; i++) lbits[i] = 1'b1;
        for (int i = 0; i + 8 < 1100; i++)
            lbits[i+8] = lbits[i] ^ lbits[i+2] ^ lbits[i+3] ^ lbits[i+4];

        tick();
        do_reset();

        // counter: 0..255,0 over 257 words, 8-cycle period
        run_phase(0, 2, 3, 257, 1);
        chk("word_count 257", word_count, 257);
        // resume counter with INTERVAL=0 -> 1,2,3
        run_phase(0, 0, 3, 3, 1);
        // walking one 01..80,01
        run_phase(1, 1, 2, 9, 1);
        // LFSR full period
        obs_q.delete();
        run_phase(2, 0, 1, 256, 1);
        chk("lfsr obs count", obs_q.size(), 256);
        distinct = 0;
        for (int i = 0; i < 255 && i < obs_q.size(); i++) begin
            if (!seenw[obs_q[i]] && obs_q[i] != 8'h00) distinct++;
            seenw[obs_q[i]] = 1'b1;
        end
        chk("lfsr distinct nonzero", distinct, 255);
        if (obs_q.size() >= 256) chk("lfsr repeat", obs_q[255], obs_q[0]);
        // constant
        const_word = 8'($urandom);
        run_phase(3, int'($urandom_range(0, 4)), 2, 3, 1);

        // ENABLE dropped while still in GAP: no START, no count
        base = start_cnt;
        mode = 2'd0;
        interval = 16'd20;
        enable = 1'b1;
        repeat (3) tick();
        enable = 1'b0;
        repeat (30) tick();
        chk("gap abort no START", start_cnt, base);
        chk("gap abort word_count", word_count, 16'(exp_wc));
        run_phase(0, 1, 2, 2, 1);

        // randomized runs
        for (int r = 0; r < 5; r++)
            run_phase(int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                      int'($urandom_range(1, 4)), int'($urandom_range(1, 6)), 1);

        // reset in the middle of the 6th counter transfer
        do_reset();
        base = start_cnt;
        push_words(0, 6);
        mode = 2'd0;
        interval = 16'd1;
        busy_len = 3;
        enable = 1'b1;
        for (int b = 0; b < 200 && start_cnt < base + 6; b++) tick();
        chk("pre-reset starts", start_cnt, base + 6);
        tick();
        tick();
        do_reset();
        repeat (4) tick();
        run_phase(0, 1, 3, 2, 1);

`ifdef SPI_TPG_TIMEOUT_EN
        begin
            logic [7:0] w;
            base = start_cnt;
            w = model_word(0, adv[0]);
            exp_q.push_back(w);   // generator is not advanced on timeout
            stuck_arm = 1;
            mode = 2'd0;
            interval = 16'd1;
            enable = 1'b1;
            for (int b = 0; b < 50 && start_cnt < base + 1; b++) tick();
            chk("timeout start", start_cnt, base + 1);
            repeat (16) tick();
            chk("ERROR before 16 XFER", error, 0);
            tick();
            chk("ERROR after 16 XFER", error, 1);
            chk("timeout DATA", data, w);
            busy_stuck = 0;
            stuck_arm = 0;
            repeat (30) tick();
            chk("timeout no START", start_cnt, base + 1);
            chk("timeout word_count", word_count, 16'(exp_wc));
            chk("ERROR sticky", error, 1);
            do_reset();
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
